// File: rtl/fir_channel_collector.sv
// Collects one 8-beat Avalon-ST frame from the multichannel FIR, rescales and saturates each
// sample to 16 bits, and commits all channels to the parallel outputs together.
//
// state    | meaning
// WAIT_SOP | idle, waiting for a ch0 beat with sop
// COLLECT  | ch0..expect_ch-1 held in shadow, waiting for channel expect_ch
module fir_channel_collector #(
  parameter int IN_WIDTH = 32,
  parameter int SHIFT    = 15
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic [2:0]          in_channel,
  input  logic                in_valid,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic [15:0]         out_channel_1,
  output logic [15:0]         out_channel_2,
  output logic [15:0]         out_channel_3,
  output logic [15:0]         out_channel_4,
  output logic [15:0]         out_channel_5,
  output logic [15:0]         out_channel_6,
  output logic [15:0]         out_channel_7,
  output logic [15:0]         out_channel_8,
  output logic                frame_valid,
  output logic                frame_clip,
  output logic                frame_error
);

  typedef enum logic [0:0] {WAIT_SOP, COLLECT} state_t;

  state_t             state, state_nxt;
  logic [2:0]         expect_ch, expect_nxt;
  logic               clip_acc, clip_nxt;
  logic               shadow_we;
  logic [2:0]         shadow_idx;
  logic               commit;
  logic               error_nxt;
  logic [6:0][15:0]   shadow;
  logic [7:0][15:0]   out_q;

  logic signed [IN_WIDTH-1:0] shifted;
  logic [IN_WIDTH-16:0]       upper;
  logic                       sat;
  logic [15:0]                sample;
  logic                       is_start;

  // The value fits in 16 bits only when everything from bit 15 upward is a pure sign extension.
  assign shifted = $signed(in_data) >>> SHIFT;
  assign upper   = shifted[IN_WIDTH-1:15];
  assign sat     = ~((&upper) | ~(|upper));
  assign sample  = sat ? (shifted[IN_WIDTH-1] ? 16'h8000 : 16'h7fff) : shifted[15:0];

  assign is_start = in_valid & in_sop & ~in_eop & (in_channel == 3'd0);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= WAIT_SOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    expect_nxt = expect_ch;
    clip_nxt   = clip_acc;
    shadow_we  = 1'b0;
    shadow_idx = expect_ch;
    commit     = 1'b0;
    error_nxt  = 1'b0;
    if (in_valid) begin
      case (state)
        WAIT_SOP: begin
          if (is_start) begin
            shadow_we  = 1'b1;
            shadow_idx = 3'd0;
            expect_nxt = 3'd1;
            clip_nxt   = sat;
            state_nxt  = COLLECT;
          end else begin
            error_nxt = 1'b1;
          end
        end
        COLLECT: begin
          if ((in_channel == expect_ch) && !in_sop && (expect_ch != 3'd7) && !in_eop) begin
            shadow_we  = 1'b1;
            expect_nxt = 3'(expect_ch + 3'd1);
            clip_nxt   = clip_acc | sat;
          end else if ((in_channel == expect_ch) && !in_sop && (expect_ch == 3'd7) && in_eop) begin
            commit    = 1'b1;
            clip_nxt  = 1'b0;
            state_nxt = WAIT_SOP;
          end else begin
            // A violating beat that is itself a clean frame start begins a new frame at once.
            error_nxt = 1'b1;
            if (is_start) begin
              shadow_we  = 1'b1;
              shadow_idx = 3'd0;
              expect_nxt = 3'd1;
              clip_nxt   = sat;
            end else begin
              clip_nxt  = 1'b0;
              state_nxt = WAIT_SOP;
            end
          end
        end
        default: state_nxt = WAIT_SOP;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      expect_ch   <= 3'd0;
      clip_acc    <= 1'b0;
      shadow      <= '0;
      out_q       <= '0;
      frame_valid <= 1'b0;
      frame_clip  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      expect_ch   <= expect_nxt;
      clip_acc    <= clip_nxt;
      frame_valid <= commit;
      frame_clip  <= commit & (clip_acc | sat);
      frame_error <= error_nxt;
      for (int i = 0; i < 7; i++) begin
        if (shadow_we && (shadow_idx == 3'(i))) shadow[i] <= sample;
      end
      if (commit) out_q <= {sample, shadow};
    end
  end

  assign out_channel_1 = out_q[0];
  assign out_channel_2 = out_q[1];
  assign out_channel_3 = out_q[2];
  assign out_channel_4 = out_q[3];
  assign out_channel_5 = out_q[4];
  assign out_channel_6 = out_q[5];
  assign out_channel_7 = out_q[6];
  assign out_channel_8 = out_q[7];

endmodule
